// File: rtl/mux4way_arb.sv
// 4-way packet-aware round-robin arbiter with a single registered output stage.
module mux4way_arb #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data_a,
  input  logic [WIDTH-1:0] in_data_b,
  input  logic [WIDTH-1:0] in_data_c,
  input  logic [WIDTH-1:0] in_data_d,
  input  logic [3:0]       in_last,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [1:0]       out_sel,
  input  logic             out_ready
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]       r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_lk;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [1:0]       r_out_sel;

  logic [0:0]       w_state_nxt;
  logic [1:0]       w_ptr_nxt;
  logic [1:0]       w_lk_nxt;
  logic             w_load_en;
  logic             w_any;
  logic [1:0]       w_grant;
  logic [1:0]       w_idx;
  logic [1:0]       w_sel;
  logic             w_xfer;
  logic [3:0]       w_in_ready;
  logic [WIDTH-1:0] w_data_sel;

  assign w_load_en = !r_out_valid || out_ready;
  assign w_any     = |in_valid;

  // Round-robin search starting at ptr; lowest offset with valid wins
  always_comb begin
    w_grant = r_ptr;
    w_idx   = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (in_valid[w_idx]) w_grant = w_idx;
    end
  end

  // State register: arbitration state, pointer, lock channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 2'd0;
      r_lk    <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_lk    <= w_lk_nxt;
    end
  end

  // Next-state, accept vector and transfer decode
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_lk_nxt    = r_lk;
    w_in_ready  = 4'b0000;
    w_sel       = w_grant;
    w_xfer      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_load_en && w_any) begin
          w_in_ready[w_grant] = 1'b1;
          w_xfer              = 1'b1;
          if (in_last[w_grant]) begin
            w_ptr_nxt = w_grant + 2'd1;
          end else begin
            w_state_nxt = LOCK;
            w_lk_nxt    = w_grant;
          end
        end
      end
      LOCK: begin
        w_sel            = r_lk;
        w_in_ready[r_lk] = w_load_en;
        if (w_load_en && in_valid[r_lk]) begin
          w_xfer = 1'b1;
          if (in_last[r_lk]) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = r_lk + 2'd1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Payload mux for the selected channel
  always_comb begin
    w_data_sel = in_data_a;
    case (w_sel)
      2'd0:    w_data_sel = in_data_a;
      2'd1:    w_data_sel = in_data_b;
      2'd2:    w_data_sel = in_data_c;
      default: w_data_sel = in_data_d;
    endcase
  end

  // Output register stage: load on transfer, drain when consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= 2'd0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data_sel;
      r_out_last  <= in_last[w_sel];
      r_out_sel   <= w_sel;
    end else if (w_load_en) begin
      r_out_valid <= 1'b0;
    end
  end

  // Accept is forced low while reset is held
  assign in_ready  = rst_n ? w_in_ready : 4'b0000;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux4way_arb.sv
// Scoreboard bench for mux4way_arb: driver runs a packet-level model, monitor checks output beats.
module tb_mux4way_arb;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic [3:0]       in_valid;
  logic [WIDTH-1:0] in_data_a, in_data_b, in_data_c, in_data_d;
  logic [3:0]       in_last;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [1:0]       out_sel;
  logic             out_ready;

  mux4way_arb #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data_a(in_data_a), .in_data_b(in_data_b),
    .in_data_c(in_data_c), .in_data_d(in_data_d),
    .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef logic [WIDTH+2:0] beat_t;   // {data, last, sel}
  beat_t exp_q[$];

  // Reference model: is the output register occupied, which channel holds a packet, rr pointer
  bit m_occ;
  int m_lk;     // -1 when no packet is open
  int m_ptr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_occ = 1'b0;
    m_lk  = -1;
    m_ptr = 0;
    exp_q.delete();
  endtask

  // One clock: drive at posedge+1, check and advance model at negedge, return at next posedge+1
  task automatic cyc(input logic [3:0] v, input logic [3:0] l,
                     input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                     input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d3,
                     input logic rdy);
    logic [WIDTH-1:0] d[4];
    logic [3:0] er;
    bit load;
    int g;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    in_valid = v; in_last = l; out_ready = rdy;
    in_data_a = d0; in_data_b = d1; in_data_c = d2; in_data_d = d3;
    load = !m_occ || rdy;
    er = 4'b0000;
    g = -1;
    if (load) begin
      if (m_lk >= 0) begin
        er[m_lk] = 1'b1;
        if (v[m_lk]) g = m_lk;
      end else begin
        for (int k = 0; k < 4; k++)
          if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        if (g >= 0) er[g] = 1'b1;
      end
    end
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(m_occ));
    if (g >= 0) begin
      exp_q.push_back({d[g], l[g], 2'(g)});
      if (l[g]) begin
        m_lk  = -1;
        m_ptr = (g + 1) % 4;
      end else begin
        m_lk = g;
      end
      m_occ = 1'b1;
    end else if (load) begin
      m_occ = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop on every output handshake, and check stability while stalled
  beat_t prev_beat;
  bit    prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid)
        chk("stall_hold", 32'({out_data, out_last, out_sel}), 32'(prev_beat));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", 32'({out_data, out_last, out_sel}), 32'hFFFF_FFFF);
        end else begin
          chk("beat", 32'({out_data, out_last, out_sel}), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_data, out_last, out_sel};
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 4'b0; in_last = 4'b0; out_ready = 1'b0;
    in_data_a = '0; in_data_b = '0; in_data_c = '0; in_data_d = '0;
    model_reset();
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // All channels single-beat, full throughput
    for (int i = 0; i < 8; i++)
      cyc(4'b1111, 4'b1111, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1);
    for (int i = 0; i < 2; i++) cyc(4'b0000, 4'b0000, '0, '0, '0, '0, 1'b1);

    // Three-beat packet on b while c waits
    for (int i = 0; i < 3; i++)
      cyc(4'b0110, (i == 2) ? 4'b0110 : 4'b0100, 16'h0, 16'(16'hB001 + i), 16'hC000, 16'h0, 1'b1);
    cyc(4'b0100, 4'b0100, '0, '0, 16'hC001, '0, 1'b1);

    // Backpressure on a held 0xBEEF beat
    cyc(4'b0001, 4'b0001, 16'hBEEF, '0, '0, '0, 1'b1);
    for (int i = 0; i < 5; i++)
      cyc(4'b1111, 4'b1111, 16'hA0A0, 16'hB0B0, 16'hC0C0, 16'hD0D0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(4'b1111, 4'b1111, 16'hA0A0, 16'hB0B0, 16'hC0C0, 16'hD0D0, 1'b1);
    cyc(4'b0000, 4'b0000, '0, '0, '0, '0, 1'b1);

    // Pointer at d, only a and d requesting: wrap d -> a -> d
    cyc(4'b0100, 4'b0100, '0, '0, 16'hCCCC, '0, 1'b1);
    for (int i = 0; i < 3; i++)
      cyc(4'b1001, 4'b1001, 16'hAAAA, '0, '0, 16'hDDDD, 1'b1);

    // Reset between edges while c holds the lock
    cyc(4'b0100, 4'b0000, '0, '0, 16'hC0DE, '0, 1'b1);
    cyc(4'b1111, 4'b0000, 16'h1, 16'h2, 16'hC0DF, 16'h4, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      cyc(4'b1111, 4'b1111, 16'h5A01, 16'h5A02, 16'h5A03, 16'h5A04, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++)
      cyc(4'($urandom), 4'($urandom) & 4'($urandom),
          16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
          ($urandom_range(0, 3) != 0));

    // Close any open packet, then drain
    while (m_lk >= 0)
      cyc(4'b1111, 4'b1111, 16'hE1, 16'hE2, 16'hE3, 16'hE4, 1'b1);
    for (int i = 0; i < 4; i++) cyc(4'b0000, 4'b0000, '0, '0, '0, '0, 1'b1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
